// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter with bounded hold, feeding a 4-bit 2:1 mux.
// Optional per-source grant counters are enabled by defining MUX_SEL_ARBITER_STATS_EN.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_1_data,
  input  logic       in_1_valid,
  output logic       in_1_ready,
  input  logic [3:0] in_2_data,
  input  logic       in_2_valid,
  output logic       in_2_ready,
  output logic       sel_out,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
`ifdef MUX_SEL_ARBITER_STATS_EN
  ,
  output logic [7:0] grant_cnt_1,
  output logic [7:0] grant_cnt_2
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_1, GRANT_2} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       load_en;
  logic       grant_1, grant_2;
  logic       take_1, take_2;

  // last: 0 = source 1 won most recently, 1 = source 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    hold_nxt   = hold_cnt;
    grant_1    = 1'b0;
    grant_2    = 1'b0;
    load_en    = !out_valid || out_ready;

    if (in_1_valid && in_2_valid) begin
      if (state == GRANT_1 && hold_cnt < HOLD_LIM)      grant_1 = 1'b1;
      else if (state == GRANT_2 && hold_cnt < HOLD_LIM) grant_2 = 1'b1;
      else if (last)                                    grant_1 = 1'b1;
      else                                              grant_2 = 1'b1;
    end else begin
      grant_1 = in_1_valid;
      grant_2 = in_2_valid;
    end

    take_1     = rst_n && load_en && grant_1;
    take_2     = rst_n && load_en && grant_2;
    in_1_ready = take_1;
    in_2_ready = take_2;

    if (load_en) begin
      if (take_1 || take_2) begin
        state_nxt = take_1 ? GRANT_1 : GRANT_2;
        last_nxt  = take_2;
        if (take_2 == last)
          hold_nxt = (hold_cnt >= HOLD_LIM) ? HOLD_LIM : hold_cnt + 4'd1;
        else
          hold_nxt = 4'd1;
      end else begin
        state_nxt = IDLE;
        hold_nxt  = 4'd0;
      end
    end
  end

  // One-entry output register; a pending beat is dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 4'h0;
      sel_out   <= 1'b0;
    end else if (load_en) begin
      if (take_1) begin
        out_valid <= 1'b1;
        out_data  <= in_1_data;
        sel_out   <= 1'b0;
      end else if (take_2) begin
        out_valid <= 1'b1;
        out_data  <= in_2_data;
        sel_out   <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SEL_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_1 <= 8'h00;
      grant_cnt_2 <= 8'h00;
    end else begin
      if (take_1) grant_cnt_1 <= grant_cnt_1 + 8'h01;
      if (take_2) grant_cnt_2 <= grant_cnt_2 + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: behavioural model compared every cycle,
// plus directed vectors with literal expectations. Define MUX_SEL_ARBITER_STATS_EN to test counters.
module tb_mux_sel_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_1_data, in_2_data;
  logic       in_1_valid, in_2_valid;
  logic       in_1_ready, in_2_ready;
  logic       sel_out;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef MUX_SEL_ARBITER_STATS_EN
  logic [7:0] grant_cnt_1, grant_cnt_2;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Model state: holder/last are source numbers (0 = none), run = consecutive grants
  int mValid, mData, mSel, mHolder, mRun, mLast, mCnt1, mCnt2;

  mux_sel_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_1_data  (in_1_data),
    .in_1_valid (in_1_valid),
    .in_1_ready (in_1_ready),
    .in_2_data  (in_2_data),
    .in_2_valid (in_2_valid),
    .in_2_ready (in_2_ready),
    .sel_out    (sel_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef MUX_SEL_ARBITER_STATS_EN
    ,
    .grant_cnt_1(grant_cnt_1),
    .grant_cnt_2(grant_cnt_2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v1, input logic [3:0] d1,
                               input bit v2, input logic [3:0] d2, input bit ordy);
    in_1_valid = v1;
    in_1_data  = d1;
    in_2_valid = v2;
    in_2_data  = d2;
    out_ready  = ordy;
  endtask

  function automatic int pickWinner(input bit v1, input bit v2, input bit ordy);
    if (mValid != 0 && !ordy) return 0;
    if (!v1 && !v2) return 0;
    if (v1 && !v2) return 1;
    if (v2 && !v1) return 2;
    if (mHolder != 0 && mRun < HOLD_MAX) return mHolder;
    return (mLast == 1) ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      mValid = 0; mData = 0; mSel = 0; mHolder = 0; mRun = 0; mLast = 2;
      mCnt1 = 0; mCnt2 = 0;
    end else if (!(mValid != 0 && !out_ready)) begin
      w = pickWinner(in_1_valid, in_2_valid, out_ready);
      if (w == 0) begin
        mValid = 0; mHolder = 0; mRun = 0;
      end else begin
        mValid  = 1;
        mData   = (w == 1) ? int'(in_1_data) : int'(in_2_data);
        mSel    = w - 1;
        mRun    = (w == mLast) ? ((mRun + 1 > HOLD_MAX) ? HOLD_MAX : mRun + 1) : 1;
        mHolder = w;
        mLast   = w;
        if (w == 1) mCnt1 = (mCnt1 + 1) % 256;
        else        mCnt2 = (mCnt2 + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (started) begin
      w = pickWinner(in_1_valid, in_2_valid, out_ready);
      checkOutput("model out_valid", out_valid, mValid);
      checkOutput("model out_data", out_data, mData);
      checkOutput("model sel_out", sel_out, mSel);
      checkOutput("model in_1_ready", in_1_ready, int'(rst_n && w == 1));
      checkOutput("model in_2_ready", in_2_ready, int'(rst_n && w == 2));
`ifdef MUX_SEL_ARBITER_STATS_EN
      checkOutput("model grant_cnt_1", grant_cnt_1, mCnt1);
      checkOutput("model grant_cnt_2", grant_cnt_2, mCnt2);
`endif
    end
  end

  int expSel [19] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,0,0,0,0,1};
  bit v2Tab  [19] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1};

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 4'h3, 1, 4'h7, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset sel_out", sel_out, 0);
    checkOutput("reset in_1_ready", in_1_ready, 0);
    checkOutput("reset in_2_ready", in_2_ready, 0);
    started = 1'b1;

    // Single source
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 4'h5, 0, 4'h0, 1);
    @(negedge clk);
    checkOutput("single in_1_ready", in_1_ready, 1);
    @(posedge clk); #1;
    checkOutput("single data0", out_data, 5);
    checkOutput("single sel0", sel_out, 0);
    checkOutput("single valid0", out_valid, 1);
    applyStimulus(1, 4'h1, 0, 4'h0, 1);
    @(posedge clk); #1;
    checkOutput("single data1", out_data, 1);
    checkOutput("single sel1", sel_out, 0);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    @(posedge clk); #1;
    checkOutput("single drained", out_valid, 0);

    // Fair hold then drop mid-hold, starting from a fresh reset
    rst_n = 1'b0;
    applyStimulus(1, 4'hA, 1, 4'hB, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1, 4'hA, v2Tab[i], 4'hB, 1);
      @(negedge clk);
      checkOutput("fair in_1_ready", in_1_ready, int'(expSel[i] == 0));
      checkOutput("fair in_2_ready", in_2_ready, int'(expSel[i] == 1));
      @(posedge clk); #1;
      checkOutput("fair sel_out", sel_out, expSel[i]);
      checkOutput("fair out_data", out_data, (expSel[i] == 1) ? 11 : 10);
    end

    // Backpressure
    applyStimulus(1, 4'h3, 1, 4'hC, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp in_1_ready", in_1_ready, 0);
      checkOutput("bp in_2_ready", in_2_ready, 0);
      checkOutput("bp out_data", out_data, 11);
      checkOutput("bp sel_out", sel_out, 1);
      checkOutput("bp out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    applyStimulus(1, 4'h3, 1, 4'hC, 1);
    @(negedge clk);
    checkOutput("resume in_2_ready", in_2_ready, 1);
    checkOutput("resume in_1_ready", in_1_ready, 0);
    @(posedge clk); #1;
    checkOutput("resume out_data", out_data, 12);
    checkOutput("resume sel_out", sel_out, 1);

    // Random traffic, including occasional mid-operation resets
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0));
      @(posedge clk); #1;
    end

`ifdef MUX_SEL_ARBITER_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 4'h9, 0, 4'h0, 1);
    repeat (300) @(posedge clk);
    #1;
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    @(negedge clk);
    checkOutput("stats grant_cnt_1", grant_cnt_1, 8'h2C);
    checkOutput("stats grant_cnt_2", grant_cnt_2, 0);
`endif

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-source round-robin arbiter that sits directly upstream of the 4-bit 2:1 standard mux. It accepts 4-bit beats from two valid/ready sources and picks one per cycle. It drives the mux select line and presents the winning beat on a registered valid/ready output. The select encoding matches the mux: 0 passes source 1, 1 passes source 2.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grants to one source while the other is waiting. Legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_1_data` in 4: source 1 beat.
- `in_1_valid` in 1: source 1 has a beat.
- `in_1_ready` out 1: source 1 beat accepted this cycle.
- `in_2_data` in 4: source 2 beat.
- `in_2_valid` in 1: source 2 has a beat.
- `in_2_ready` out 1: source 2 beat accepted this cycle.
- `sel_out` out 1: registered mux select, the source of the beat currently in `out_data`.
- `out_data` out 4: registered winning beat.
- `out_valid` out 1: `out_data` holds an undelivered beat.
- `out_ready` in 1: downstream accepts `out_data`.

## Operation
- The block has a one-entry output register.
- Load enable: `load_en = !out_valid | out_ready`.
- State machine has three states:
  - IDLE: no grant held.
  - GRANT_1: source 1 holds the grant.
  - GRANT_2: source 2 holds the grant.
- Internal registers:
  - `last`: last granted source.
  - `hold_cnt`: 4-bit count of consecutive grants, saturating at HOLD_MAX.
- Arbitration is evaluated only when `load_en` = 1:
  - Neither source valid: no transfer; state goes to IDLE; `hold_cnt` goes to 0; `last` is unchanged.
  - Exactly one source valid: grant that source.
  - Both valid, state is GRANT_k and `hold_cnt < HOLD_MAX`: grant source k.
  - Both valid otherwise (IDLE, or hold exhausted): grant the source that is not `last`.
- `in_k_ready` = `load_en` AND source k is granted this cycle. Ready therefore implies a transfer.
  - Ready depends combinationally on both valids and on `out_ready`.
  - Sources must not make valid depend on ready.
- On a transfer from source k:
  - `out_data` <= `in_k_data`, `out_valid` <= 1, `sel_out` <= k-1.
  - State <= GRANT_k, `last` <= k.
  - `hold_cnt` <= min(`hold_cnt`+1, HOLD_MAX) if k equals `last`, else 1.
- `load_en` = 1 with no transfer: `out_valid` <= 0. `out_data` and `sel_out` hold their values.
- `load_en` = 0: all registers hold. `out_data` and `sel_out` stay stable while `out_valid` & !`out_ready`.
- Reset values:
  - `out_valid` 0, `out_data` 4'h0, `sel_out` 0.
  - State IDLE, `hold_cnt` 0, `last` = source 2, so source 1 wins the first tie.
  - Both readies are 0 while `rst_n` = 0.

## Timing
- Latency: 1 cycle from an accepted input beat to `out_valid`.
- Throughput: one beat per cycle while `out_ready` = 1.
- Backpressure: `out_ready` = 0 with `out_valid` = 1 deasserts both readies in the same cycle.
- Output drain and new input load in the same cycle are supported; there is no bubble.
- Fairness: with both sources continuously valid, grants run in blocks of HOLD_MAX per source.
- Hold counter saturates and never wraps.
- A source dropping valid mid-hold moves the grant immediately to the other source, if it is valid.
- Reset mid-operation: reset takes effect on the next edge regardless of handshake state, and any pending output beat is discarded.

## Configuration
- Macro: `MUX_SEL_ARBITER_STATS_EN`.
- Defined: adds two outputs, `grant_cnt_1` out 8 and `grant_cnt_2` out 8.
  - Each counts transfers from its source and wraps 8'hFF -> 8'h00.
  - Both are 0 at reset.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with both sources valid.
  - Required: `out_valid` = 0, `out_data` = 4'h0, `sel_out` = 0, both readies 0.
- Single source: source 1 only sends 4'h5, 4'h1; `out_ready` = 1.
  - Required: `out_data` 4'h5 then 4'h1, one cycle after each accept, with `sel_out` = 0.
- Fair hold: HOLD_MAX = 4, both sources valid continuously (source 1 = 4'hA, source 2 = 4'hB), `out_ready` = 1.
  - Required: `sel_out` sequence 0,0,0,0,1,1,1,1,0; the first grant goes to source 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `out_valid` = 1.
  - Required: `out_data` and `sel_out` stable, `in_1_ready` = `in_2_ready` = 0; delivery resumes the cycle `out_ready` returns to 1.
- Drop mid-hold: source 2 holds the grant (`hold_cnt` = 2), then drops valid while source 1 is valid.
  - Required: next output has `sel_out` = 0 and `hold_cnt` restarts at 1.
- Stats (macro defined): 300 source-1 transfers.
  - Required: `grant_cnt_1` = 8'h2C (300 mod 256), `grant_cnt_2` = 0.
